// File: rtl/shift_restore_unit.sv
// Serial shifter: captures a word and a shift count, then shifts one bit per
// cycle until the count runs out, with a start/busy/done handshake.
module shift_restore_unit #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              dir,
    input  logic [CNT_W-1:0]  shift_amt,
    input  logic [DATA_W-1:0] data_in,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] data_out,
    output logic [CNT_W-1:0]  bits_left,
    output logic              cnt_zero
);

    // state    | meaning
    // ST_IDLE  | waiting for start, registers hold last result
    // ST_SHIFT | one single-bit shift per cycle, bits_left counts down
    // ST_DONE  | one-cycle done pulse, data_out holds final value
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               dir_q;
    logic               dir_d;
    logic [DATA_W-1:0]  data_d;
    logic [CNT_W-1:0]   bits_d;
    logic               busy_d;
    logic               done_d;

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        data_d  = data_out;
        bits_d  = bits_left;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    data_d  = data_in;
                    bits_d  = shift_amt;
                    dir_d   = dir;
                    state_d = (shift_amt != '0) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                data_d = dir_q ? (data_out >> 1) : (data_out << 1);
                // Guarded decrement so the counter can never wrap.
                if (bits_left != '0) begin
                    bits_d = bits_left - CNT_W'(1);
                end
                if (bits_left <= CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Outputs are registered from the next state so they align with it.
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            dir_q     <= 1'b0;
            data_out  <= '0;
            bits_left <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            data_out  <= data_d;
            bits_left <= bits_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    assign cnt_zero = ~|bits_left;

endmodule

// File: tb/tb_shift_restore_unit.sv
// Directed bench for shift_restore_unit: expected results are queued at start
// and popped when done is seen.
module tb_shift_restore_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        dir;
    logic [4:0]  shift_amt;
    logic [15:0] data_in;
    logic        busy;
    logic        done;
    logic [15:0] data_out;
    logic [4:0]  bits_left;
    logic        cnt_zero;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] data;
        int          lat;
    } exp_t;

    exp_t sb[$];

    shift_restore_unit #(.DATA_W(16), .CNT_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dir       (dir),
        .shift_amt (shift_amt),
        .data_in   (data_in),
        .busy      (busy),
        .done      (done),
        .data_out  (data_out),
        .bits_left (bits_left),
        .cnt_zero  (cnt_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] d, input int amt,
                          input logic dr, input bit inject);
        exp_t        e;
        logic [15:0] m;
        int          cycles;
        int          busy_n;
        m = d;
        for (int i = 0; i < amt; i++) m = dr ? (m >> 1) : (m << 1);
        e.data = m;
        e.lat  = amt + 1;
        sb.push_back(e);

        data_in   = d;
        shift_amt = amt[4:0];
        dir       = dr;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        data_in   = ~d;
        dir       = ~dr;
        shift_amt = 5'd7;
        cycles    = 1;
        busy_n    = 0;
        check({tag, "_bits_first"}, bits_left, amt);
        while (done !== 1'b1 && cycles < 40) begin
            if (busy === 1'b1) busy_n++;
            if (inject && cycles == 1) begin
                start     = 1'b1;
                shift_amt = 5'd9;
                data_in   = 16'h5A5A;
            end
            @(posedge clk); #1;
            start = 1'b0;
            cycles++;
        end
        if (busy === 1'b1) busy_n++;
        check({tag, "_done_seen"}, done, 1);
        check({tag, "_sb_depth"}, sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_data"}, data_out, e.data);
            check({tag, "_latency"}, cycles, e.lat);
            check({tag, "_busy_cycles"}, busy_n, e.lat);
            check({tag, "_bits_end"}, bits_left, 0);
            check({tag, "_cnt_zero"}, cnt_zero, 1);
            @(posedge clk); #1;
            check({tag, "_idle_busy"}, busy, 0);
            check({tag, "_idle_done"}, done, 0);
            check({tag, "_idle_hold"}, data_out, e.data);
        end
    endtask

    initial begin
        bit saw_done;
        rst       = 1'b1;
        start     = 1'b0;
        dir       = 1'b0;
        shift_amt = '0;
        data_in   = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("reset_data", data_out, 0);
        check("reset_bits", bits_left, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_cnt_zero", cnt_zero, 1);

        run_op("left4",     16'h0001, 4,  1'b0, 1'b0);
        run_op("right15",   16'h8000, 15, 1'b1, 1'b0);
        run_op("amt0",      16'hA5C3, 0,  1'b0, 1'b0);
        run_op("over20",    16'hFFFF, 20, 1'b0, 1'b0);
        run_op("ignore",    16'h0003, 3,  1'b0, 1'b1);
        run_op("right31",   16'hFFFF, 31, 1'b1, 1'b0);

        // Reset asserted during the third SHIFT cycle.
        saw_done  = 1'b0;
        data_in   = 16'h1234;
        shift_amt = 5'd10;
        dir       = 1'b0;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (done === 1'b1) saw_done = 1'b1;
        @(posedge clk); #1;
        if (done === 1'b1) saw_done = 1'b1;
        @(posedge clk); #1;
        if (done === 1'b1) saw_done = 1'b1;
        check("midrst_busy_before", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_data", data_out, 0);
        check("midrst_bits", bits_left, 0);
        check("midrst_busy", busy, 0);
        check("midrst_cnt_zero", cnt_zero, 1);
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1) saw_done = 1'b1;
            @(posedge clk); #1;
        end
        check("midrst_no_done", saw_done, 0);
        check("midrst_still_idle", busy, 0);

        run_op("after_rst", 16'h0101, 2, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
